// File: rtl/shifter_pkg.sv
// Mode encoding and bit-order helpers shared by the barrel shifter and its stages.
package shifter_pkg;

  localparam int MODE_W = 3;
  // Widest operand the reversal helper can handle; callers zero-extend into it.
  localparam int REV_W  = 256;

  typedef enum logic [MODE_W-1:0] {
    MODE_SLL = 3'd0,
    MODE_SRL = 3'd1,
    MODE_SRA = 3'd2,
    MODE_ROL = 3'd3,
    MODE_ROR = 3'd4
  } shift_mode_e;

  function automatic logic [REV_W-1:0] reverse_bits(input logic [REV_W-1:0] v);
    logic [REV_W-1:0] r;
    r = {<<{v}};
    return r;
  endfunction

  function automatic logic is_right_mode(input logic [MODE_W-1:0] m);
    logic r;
    case (m)
      MODE_SRL, MODE_SRA, MODE_ROR: r = 1'b1;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_rotate_mode(input logic [MODE_W-1:0] m);
    logic r;
    case (m)
      MODE_ROL, MODE_ROR: r = 1'b1;
      default:            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_reserved_mode(input logic [MODE_W-1:0] m);
    logic r;
    case (m)
      MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR: r = 1'b0;
      default:                                          r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One pipeline slice: a contiguous run of left-shift mux levels followed by an
// optional valid/data register that loads when empty or when downstream loads.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int N          = 16,
  parameter int LEVEL_LO   = 0,
  parameter int LEVEL_HI   = 1,
  parameter bit REGISTERED = 1'b1,
  parameter bit FINAL      = 1'b0,
  localparam int L         = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [N-1:0]      up_data,
  input  logic [L-1:0]      up_amt,
  input  logic [MODE_W-1:0] up_mode,
  input  logic              up_shift_in,
  input  logic              up_msb,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [N-1:0]      dn_data,
  output logic [L-1:0]      dn_amt,
  output logic [MODE_W-1:0] dn_mode,
  output logic              dn_shift_in,
  output logic              dn_msb,
  output logic              dn_zero,
  output logic              dn_error
);

  logic          fill_bit_s;
  logic          rotate_s;
  logic [N-1:0]  lvl_s [LEVEL_LO:LEVEL_HI+1];
  logic [N-1:0]  result_s;
  logic          zero_s;
  logic          error_s;

  // Right-hand modes arrive bit-reversed, so every level is a left shift/rotate.
  assign fill_bit_s = (up_mode == MODE_SRA) ? up_msb : up_shift_in;
  assign rotate_s   = is_rotate_mode(up_mode);
  assign lvl_s[LEVEL_LO] = up_data;

  for (genvar i = LEVEL_LO; i <= LEVEL_HI; i++) begin : g_level
    localparam int S = 2 ** i;
    assign lvl_s[i+1] = !up_amt[i] ? lvl_s[i] :
                        rotate_s   ? {lvl_s[i][N-1-S:0], lvl_s[i][N-1:N-S]} :
                                     {lvl_s[i][N-1-S:0], {S{fill_bit_s}}};
  end

  // Final slice undoes the input reversal and derives the result flags.
  always_comb begin
    result_s = lvl_s[LEVEL_HI+1];
    zero_s   = 1'b0;
    error_s  = 1'b0;
    if (FINAL) begin
      if (is_right_mode(up_mode)) begin
        result_s = N'(reverse_bits(REV_W'(lvl_s[LEVEL_HI+1])) >> (REV_W - N));
      end else begin
        result_s = lvl_s[LEVEL_HI+1];
      end
      zero_s  = (result_s == {N{1'b0}});
      error_s = is_reserved_mode(up_mode);
    end else begin
      result_s = lvl_s[LEVEL_HI+1];
    end
  end

  if (REGISTERED) begin : g_reg
    logic              load_s;
    logic              valid_q,    valid_d;
    logic [N-1:0]      data_q,     data_d;
    logic [L-1:0]      amt_q,      amt_d;
    logic [MODE_W-1:0] mode_q,     mode_d;
    logic              shift_in_q, shift_in_d;
    logic              msb_q,      msb_d;
    logic              zero_q,     zero_d;
    logic              error_q,    error_d;

    assign load_s   = !valid_q || dn_ready;
    assign up_ready = load_s;

    // Next-state: take the upstream beat on load, keep payload across bubbles.
    always_comb begin
      valid_d    = valid_q;
      data_d     = data_q;
      amt_d      = amt_q;
      mode_d     = mode_q;
      shift_in_d = shift_in_q;
      msb_d      = msb_q;
      zero_d     = zero_q;
      error_d    = error_q;
      if (load_s) begin
        valid_d = up_valid;
        if (up_valid) begin
          data_d     = result_s;
          amt_d      = up_amt;
          mode_d     = up_mode;
          shift_in_d = up_shift_in;
          msb_d      = up_msb;
          zero_d     = zero_s;
          error_d    = error_s;
        end else begin
          zero_d  = 1'b0;
          error_d = 1'b0;
        end
      end else begin
        valid_d = valid_q;
      end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q    <= 1'b0;
        data_q     <= {N{1'b0}};
        amt_q      <= {L{1'b0}};
        mode_q     <= {MODE_W{1'b0}};
        shift_in_q <= 1'b0;
        msb_q      <= 1'b0;
        zero_q     <= 1'b0;
        error_q    <= 1'b0;
      end else begin
        valid_q    <= valid_d;
        data_q     <= data_d;
        amt_q      <= amt_d;
        mode_q     <= mode_d;
        shift_in_q <= shift_in_d;
        msb_q      <= msb_d;
        zero_q     <= zero_d;
        error_q    <= error_d;
      end
    end

    assign dn_valid    = valid_q;
    assign dn_data     = data_q;
    assign dn_amt      = amt_q;
    assign dn_mode     = mode_q;
    assign dn_shift_in = shift_in_q;
    assign dn_msb      = msb_q;
    assign dn_zero     = zero_q;
    assign dn_error    = error_q;
  end else begin : g_comb
    assign up_ready    = dn_ready;
    assign dn_valid    = up_valid;
    assign dn_data     = result_s;
    assign dn_amt      = up_amt;
    assign dn_mode     = up_mode;
    assign dn_shift_in = up_shift_in;
    assign dn_msb      = up_msb;
    assign dn_zero     = up_valid && zero_s;
    assign dn_error    = up_valid && error_s;
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter: right modes are reversed into a shared
// left-shift datapath split across P registered slices with valid/ready flow.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int N         = 16,
  parameter int REG_EVERY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] shift_amount,
  input  logic [MODE_W-1:0]    mode,
  input  logic                 shift_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 out_zero,
  output logic                 out_error
);

  localparam int L = $clog2(N);
  localparam int P = (L + REG_EVERY - 1) / REG_EVERY;

  logic [P:0]        valid_s;
  logic [P:0]        ready_s;
  logic [N-1:0]      data_s     [P+1];
  logic [L-1:0]      amt_s      [P+1];
  logic [MODE_W-1:0] mode_s     [P+1];
  logic              shift_in_s [P+1];
  logic              msb_s      [P+1];
  logic              zero_s     [P];
  logic              error_s    [P];

  // Reserved modes pass the operand through untouched, hence the zeroed amount.
  assign valid_s[0]    = in_valid;
  assign data_s[0]     = is_right_mode(mode) ?
                         N'(reverse_bits(REV_W'(in_data)) >> (REV_W - N)) : in_data;
  assign amt_s[0]      = is_reserved_mode(mode) ? {L{1'b0}} : shift_amount;
  assign mode_s[0]     = mode;
  assign shift_in_s[0] = shift_in;
  assign msb_s[0]      = in_data[N-1];
  assign ready_s[P]    = out_ready;

  for (genvar s = 0; s < P; s++) begin : g_stage
    localparam int LO = s * REG_EVERY;
    localparam int HI = ((s + 1) * REG_EVERY > L) ? (L - 1) : ((s + 1) * REG_EVERY - 1);

    shift_stage #(
      .N          (N),
      .LEVEL_LO   (LO),
      .LEVEL_HI   (HI),
      .REGISTERED (1'b1),
      .FINAL      (s == P - 1)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .up_valid    (valid_s[s]),
      .up_ready    (ready_s[s]),
      .up_data     (data_s[s]),
      .up_amt      (amt_s[s]),
      .up_mode     (mode_s[s]),
      .up_shift_in (shift_in_s[s]),
      .up_msb      (msb_s[s]),
      .dn_valid    (valid_s[s+1]),
      .dn_ready    (ready_s[s+1]),
      .dn_data     (data_s[s+1]),
      .dn_amt      (amt_s[s+1]),
      .dn_mode     (mode_s[s+1]),
      .dn_shift_in (shift_in_s[s+1]),
      .dn_msb      (msb_s[s+1]),
      .dn_zero     (zero_s[s]),
      .dn_error    (error_s[s])
    );
  end

  assign in_ready  = ready_s[0];
  assign out_valid = valid_s[P];
  assign out_data  = data_s[P];
  assign out_zero  = zero_s[P-1];
  assign out_error = error_s[P-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter at N=16, REG_EVERY=2 (two stages).
module tb_pipelined_barrel_shifter;
  import shifter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  shift_amount;
  logic [2:0]  mode;
  logic        shift_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
  logic        out_error;

  int checks = 0;
  int passed = 0;

  pipelined_barrel_shifter #(.N(16), .REG_EVERY(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .shift_amount (shift_amount),
    .mode         (mode),
    .shift_in     (shift_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_zero     (out_zero),
    .out_error    (out_error)
  );

  always #5 clk = ~clk;

  // Drive one beat into an otherwise idle pipe and return the result and the
  // number of clock edges from acceptance to the first OutValid sample.
  task automatic run_beat(input logic [15:0] d, input logic [3:0] a, input logic [2:0] m,
                          input logic si, output logic [15:0] od, output logic oz,
                          output logic oe, output int lat);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = d; shift_amount = a; mode = m; shift_in = si;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    od = out_data; oz = out_zero; oe = out_error;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (out_data !== 16'h0000) $display("FAIL reset_out_data: got %h expected 0000", out_data); else passed++;
    checks++; if (out_zero !== 1'b0) $display("FAIL reset_out_zero: got %b expected 0", out_zero); else passed++;
    checks++; if (out_error !== 1'b0) $display("FAIL reset_out_error: got %b expected 0", out_error); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
  endtask

  task automatic test_sll;
    logic [15:0] od; logic oz, oe; int lat;
    run_beat(16'h0001, 4'd4, MODE_SLL, 1'b0, od, oz, oe, lat);
    checks++; if (od !== 16'h0010) $display("FAIL sll_amt4: got %h expected 0010", od); else passed++;
    checks++; if (lat !== 2) $display("FAIL sll_latency: got %0d expected 2", lat); else passed++;
    run_beat(16'h0001, 4'd3, MODE_SLL, 1'b1, od, oz, oe, lat);
    checks++; if (od !== 16'h000F) $display("FAIL sll_fill1: got %h expected 000f", od); else passed++;
    checks++; if (lat !== 2) $display("FAIL sll_fill1_latency: got %0d expected 2", lat); else passed++;
  endtask

  task automatic test_right;
    logic [15:0] od; logic oz, oe; int lat;
    run_beat(16'h8000, 4'd15, MODE_SRA, 1'b0, od, oz, oe, lat);
    checks++; if (od !== 16'hFFFF) $display("FAIL sra_neg15: got %h expected ffff", od); else passed++;
    run_beat(16'h4000, 4'd2, MODE_SRA, 1'b1, od, oz, oe, lat);
    checks++; if (od !== 16'h1000) $display("FAIL sra_pos2: got %h expected 1000", od); else passed++;
    run_beat(16'h8000, 4'd15, MODE_SRL, 1'b0, od, oz, oe, lat);
    checks++; if (od !== 16'h0001) $display("FAIL srl_15: got %h expected 0001", od); else passed++;
    checks++; if (oz !== 1'b0) $display("FAIL srl_15_zero: got %b expected 0", oz); else passed++;
    run_beat(16'h0001, 4'd1, MODE_SRL, 1'b0, od, oz, oe, lat);
    checks++; if (od !== 16'h0000) $display("FAIL srl_to_zero: got %h expected 0000", od); else passed++;
    checks++; if (oz !== 1'b1) $display("FAIL srl_to_zero_flag: got %b expected 1", oz); else passed++;
    run_beat(16'h0000, 4'd4, MODE_SRL, 1'b1, od, oz, oe, lat);
    checks++; if (od !== 16'hF000) $display("FAIL srl_fill1: got %h expected f000", od); else passed++;
  endtask

  task automatic test_rotate;
    logic [15:0] od; logic oz, oe; int lat;
    run_beat(16'h0001, 4'd1, MODE_ROR, 1'b0, od, oz, oe, lat);
    checks++; if (od !== 16'h8000) $display("FAIL ror_1: got %h expected 8000", od); else passed++;
    run_beat(16'h1234, 4'd4, MODE_ROR, 1'b1, od, oz, oe, lat);
    checks++; if (od !== 16'h4123) $display("FAIL ror_4: got %h expected 4123", od); else passed++;
    run_beat(16'h8001, 4'd4, MODE_ROL, 1'b0, od, oz, oe, lat);
    checks++; if (od !== 16'h0018) $display("FAIL rol_4: got %h expected 0018", od); else passed++;
    run_beat(16'hA5C3, 4'd0, MODE_ROL, 1'b1, od, oz, oe, lat);
    checks++; if (od !== 16'hA5C3) $display("FAIL rol_0: got %h expected a5c3", od); else passed++;
  endtask

  task automatic test_reserved;
    logic [15:0] od; logic oz, oe; int lat;
    run_beat(16'hBEEF, 4'd5, 3'd6, 1'b1, od, oz, oe, lat);
    checks++; if (od !== 16'hBEEF) $display("FAIL reserved_data: got %h expected beef", od); else passed++;
    checks++; if (oe !== 1'b1) $display("FAIL reserved_error: got %b expected 1", oe); else passed++;
    run_beat(16'h0003, 4'd2, MODE_SLL, 1'b0, od, oz, oe, lat);
    checks++; if (od !== 16'h000C) $display("FAIL legal_after_reserved: got %h expected 000c", od); else passed++;
    checks++; if (oe !== 1'b0) $display("FAIL legal_error_clear: got %b expected 0", oe); else passed++;
  endtask

  task automatic test_back_to_back;
    int idx, got, first, last;
    logic stable, ready_at_release;
    logic [15:0] res [4];
    idx = 0; stable = 1'b1;
    // Stall phase: OutReady low for five cycles while offering four beats.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0; mode = MODE_SLL; shift_amount = 4'd1; shift_in = 1'b0;
      if (idx < 4) begin in_valid = 1'b1; in_data = 16'(idx + 1); end
      else in_valid = 1'b0;
      #1;
      if (c >= 2 && (out_valid !== 1'b1 || out_data !== 16'h0002)) stable = 1'b0;
      if (in_valid && in_ready) idx++;
    end
    checks++; if (idx !== 2) $display("FAIL bp_accepted: got %0d expected 2", idx); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); else passed++;
    checks++; if (stable !== 1'b1) $display("FAIL bp_out_stable: got %b expected 1", stable); else passed++;
    got = 0; first = -1; last = -1; ready_at_release = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (idx < 4) begin in_valid = 1'b1; in_data = 16'(idx + 1); end
      else in_valid = 1'b0;
      #1;
      if (c == 0) ready_at_release = in_ready;
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        if (got < 4) res[got] = out_data;
        got++;
        if (first < 0) first = c;
        last = c;
      end
    end
    in_valid = 1'b0;
    checks++; if (ready_at_release !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", ready_at_release); else passed++;
    checks++; if (got !== 4) $display("FAIL bp_result_count: got %0d expected 4", got); else passed++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= got || res[k] !== 16'((k + 1) * 2))
        $display("FAIL bp_result_%0d: got %h expected %h", k, (k < got) ? res[k] : 16'hxxxx, 16'((k + 1) * 2));
      else passed++;
    end
    checks++; if (last - first !== 3) $display("FAIL bp_no_bubble: got span %0d expected 3", last - first); else passed++;
  endtask

  task automatic test_reset_midflight;
    logic stale;
    @(negedge clk);
    out_ready = 1'b0; mode = MODE_SLL; shift_amount = 4'd1; shift_in = 1'b0;
    in_valid = 1'b1; in_data = 16'h0005;
    @(negedge clk);
    in_data = 16'h0006;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b expected 1", out_valid); else passed++;
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (out_data !== 16'h0000) $display("FAIL mid_rst_data: got %h expected 0000", out_data); else passed++;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL mid_post_ready: got %b expected 1", in_ready); else passed++;
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) $display("FAIL mid_no_stale: got %b expected 0", stale); else passed++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; shift_amount = 4'd0;
    mode = 3'd0; shift_in = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_sll();
    test_right();
    test_rotate();
    test_reserved();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
# pipelined_barrel_shifter

Parametrised, pipelined, multi-mode barrel shifter.
- Modes: logical left/right with programmable fill, arithmetic right, rotate left/right.
- Valid/ready handshake on input and output; backpressure stalls the pipeline without data loss.
- Used in ALU and datapath stages that need single-cycle throughput at wider N than a purely combinational shifter can close timing on.

## Interface
- N, 16: data width; power of two, ≥4.
- REG_EVERY, 2: mux levels per pipeline register; range 1..log2(N).
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- InValid  input  1  input beat valid.
- InReady  output  1  block can accept a beat this cycle.
- In  input  N  operand.
- ShiftAmount  input  log2(N)  shift/rotate distance.
- Mode  input  3  0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR; 5–7 reserved.
- ShiftIn  input  1  fill bit for SLL/SRL.
- OutValid  output  1  result valid.
- OutReady  input  1  downstream accepts result.
- Out  output  N  result.
- OutZero  output  1  Out == 0, qualified by OutValid.
- OutError  output  1  reserved Mode was used for this beat.

## Operation
- L = log2(N) mux levels; level i shifts by 2^i when ShiftAmount[i] = 1.
- Registers:
  - P = ceil(L / REG_EVERY) pipeline registers.
  - A register sits after levels REG_EVERY-1, 2·REG_EVERY-1, …, and always after the final level.
- Beats carry through the pipeline: Mode, ShiftIn, the remaining ShiftAmount bits, and the MSB of In (needed for SRA fill).
- Right shifts and rotates are realised by bit-reversing into the left-shift datapath and reversing at the output. Output is identical to direct implementation.
- SLL/SRL: vacated bits take ShiftIn.
- SRA: vacated bits take original In[N-1].
- ROL/ROR: no fill; ShiftAmount 0 passes In unchanged.
- Reserved Mode (5–7): Out = In, OutError = 1.
- OutZero is computed from the final registered Out.
- Handshake:
  - Transfer occurs when Valid && Ready.
  - Each register stage holds one beat. Stage k loads when it is empty or stage k+1 loads in the same cycle. The last stage loads when it is empty or OutReady = 1.
  - InReady = stage-0 load condition. It is combinational from OutReady and the valid bits only, never from InValid.
  - Out, OutZero and OutError stay stable while OutValid && !OutReady.

## Timing
- Reset values:
  - All stage valid bits 0.
  - Out = 0, OutZero = 0, OutError = 0, OutValid = 0.
  - InReady = 1 immediately after reset deasserts, because the pipeline is empty.
- Latency: a beat accepted at edge t appears with OutValid = 1 after edge t+P-1, i.e. P cycles in flight.
- Throughput: one beat per cycle while OutReady = 1.
- Capacity: P beats. With OutReady held low, at most P beats are accepted, then InReady = 0.
- Simultaneous events:
  - When the pipeline is full and OutReady rises, InReady = 1 in the same cycle, so accept and drain happen together.
  - OutValid && OutReady with InValid on the same edge: no bubble.
- Reset mid-operation: all in-flight beats are discarded and outputs return to reset values asynchronously. No partial beat is ever emitted.
- ShiftAmount width is exactly log2(N); no amount ≥ N is representable.

## Structure
- Package shifter_pkg holds:
  - shift_mode_e enum (SLL, SRL, SRA, ROL, ROR).
  - MODE_W = 3.
  - Function reverse_bits.
- Sub-module shift_stage (N, LEVEL_LO, LEVEL_HI, REGISTERED) implements a contiguous group of mux levels plus an optional valid/data register with the load rule above.
- Top level generates P instances of shift_stage and handles reversal, fill, and the output flags.

## Test plan
All scenarios use N=16, REG_EVERY=2, so P=2.
- SLL, In=0x0001, amt 4, ShiftIn 0 → Out=0x0010 two cycles after accept. Same with amt 3, ShiftIn 1 → 0x000F.
- SRA In=0x8000 amt 15 → 0xFFFF. SRL In=0x8000 amt 15 ShiftIn 0 → 0x0001, OutZero 0. SRL In=0x0001 amt 1 ShiftIn 0 → 0x0000, OutZero 1.
- ROR In=0x0001 amt 1 → 0x8000. ROL In=0x8001 amt 4 → 0x0018. ROL amt 0 → In unchanged.
- Backpressure:
  - Stimulus: OutReady low 5 cycles, 4 back-to-back beats (0x1,0x2,0x3,0x4 SLL amt 1).
  - Required: exactly 2 accepted, then InReady=0; Out held stable while stalled.
  - On release: results 0x2,0x4,0x6,0x8 in order, no loss, no bubble.
- Reserved Mode 6, In=0xBEEF → Out=0xBEEF, OutError=1. The next legal beat has OutError=0.
- Reset asserted with 2 beats in flight → OutValid=0, Out=0 immediately, InReady=1 after release, no stale beat emitted.
